// File: rtl/aes_out_misr.sv
// MISR signature compactor for the AES ciphertext stream, with a programmable start latency.
// Optional golden-signature comparator enabled by defining MISR_COMPARE_EN.
module aes_out_misr #(
    parameter int unsigned  LATENCY = 21,
    parameter logic [127:0] SEED    = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic [31:0]  i_num_samples,
    input  logic [127:0] i_data,
    input  logic [127:0] i_expected,
    output logic         o_busy,
    output logic         o_done,
    output logic [127:0] o_signature,
    output logic         o_match,
    output logic [31:0]  o_sample_count
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_COMPACT = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    // WAIT spans LATENCY-1 cycles; with LATENCY==1 it is skipped entirely.
    localparam bit          NO_WAIT   = (LATENCY < 2);
    localparam logic [31:0] WAIT_LOAD = NO_WAIT ? 32'd0 : 32'(LATENCY - 2);

    logic [1:0]   state_q, state_d;
    logic [31:0]  wcnt_q, wcnt_d;
    logic [31:0]  n_q, n_d;
    logic [127:0] sig_q, sig_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         start_acc;
    logic         done_entry;
    logic         fb;
    logic [127:0] sig_step;

    assign fb       = sig_q[127] ^ sig_q[125] ^ sig_q[100] ^ sig_q[98];
    assign sig_step = {sig_q[126:0], fb} ^ i_data;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        n_d        = n_q;
        sig_d      = sig_q;
        cnt_d      = cnt_q;
        start_acc  = 1'b0;
        done_entry = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    n_d       = i_num_samples;
                    sig_d     = SEED;
                    cnt_d     = 32'd0;
                    wcnt_d    = WAIT_LOAD;
                    if (i_num_samples == 32'd0) begin
                        state_d    = S_DONE;
                        done_entry = 1'b1;
                    end else if (NO_WAIT) begin
                        state_d = S_COMPACT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 32'd0) begin
                    state_d = S_COMPACT;
                end else begin
                    wcnt_d = wcnt_q - 32'd1;
                end
            end
            S_COMPACT: begin
                sig_d = sig_step;
                cnt_d = cnt_q + 32'd1;
                if (cnt_d == n_q) begin
                    state_d    = S_DONE;
                    done_entry = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 32'd0;
            n_q     <= 32'd0;
            sig_q   <= SEED;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            n_q     <= n_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef MISR_COMPARE_EN
    logic match_q;

    // Compare against the signature being written on the DONE entry edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else if (done_entry) begin
            match_q <= (sig_d == i_expected);
        end else if (start_acc) begin
            match_q <= 1'b0;
        end
    end

    assign o_match = match_q;
`else
    logic unused_cmp;

    assign unused_cmp = ^{i_expected, start_acc, done_entry};
    assign o_match    = 1'b0;
`endif

    assign o_busy         = (state_q == S_WAIT) || (state_q == S_COMPACT);
    assign o_done         = (state_q == S_DONE);
    assign o_signature    = sig_q;
    assign o_sample_count = cnt_q;

endmodule
